// File: rtl/sccb_target_regfile.sv
// SCCB/I2C target with a 256 x 8-bit register file.
// Decodes 3-phase writes and 2-phase reads from oversampled SCL/SDA.
// Every register write is reported to the host side.
// The host can read any register at any time through a combinational port.
module sccb_target_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_SUB_ADDR, S_SUB_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_MACK, S_IGNORE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_q, sda_q;
    logic                   scl, sda;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;

    logic [3:0] bit_cnt, bit_cnt_n;
    logic [6:0] shreg, shreg_n;    // 7 bits: the 8th bit is taken straight from the line / regfile
    logic [7:0] ptr, ptr_n;
    logic       sda_oe_n, busy_n, rw, rw_n, we;
    logic [7:0] rx_byte, rd_byte;
    logic [7:0] regs [256];

    // Synchronisers plus one history flop; idle bus level is high so reset to 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q    <= scl;
            sda_q    <= sda;
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start_ev = scl & scl_q & sda_q & ~sda;
    assign stop_ev  = scl & scl_q & ~sda_q & sda;

    assign rx_byte    = {shreg, sda};
    assign rd_byte    = regs[ptr];
    assign host_rdata = regs[host_addr];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state and next datapath values; START/STOP override everything
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ptr_n     = ptr;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        rw_n      = rw;
        we        = 1'b0;
        if (start_ev) begin
            state_n   = S_DEV_ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b1;
        end else if (stop_ev) begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                S_DEV_ADDR, S_SUB_ADDR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte[6:0];
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            if (state == S_DEV_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    rw_n    = rx_byte[0];
                                    state_n = S_DEV_ACK;
                                end else begin
                                    state_n = S_IGNORE;
                                end
                            end else if (state == S_SUB_ADDR) begin
                                ptr_n   = rx_byte;
                                state_n = S_SUB_ACK;
                            end else begin
                                we      = 1'b1;
                                ptr_n   = ptr + 8'd1;
                                state_n = S_WR_ACK;
                            end
                        end
                    end
                end
                // sda_oe is always released on entry, so it doubles as the ACK phase flag
                S_DEV_ACK, S_SUB_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            if (state == S_DEV_ACK && rw) begin
                                // the edge ending the ACK already drives the first read bit
                                shreg_n   = rd_byte[6:0];
                                sda_oe_n  = ~rd_byte[7];
                                bit_cnt_n = 4'd1;
                                state_n   = S_RD_DATA;
                            end else if (state == S_DEV_ACK) begin
                                state_n = S_SUB_ADDR;
                            end else begin
                                state_n = S_WR_DATA;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            shreg_n   = rd_byte[6:0];
                            sda_oe_n  = ~rd_byte[7];
                            bit_cnt_n = 4'd1;
                        end else if (bit_cnt == 4'd8) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = S_RD_MACK;
                        end else begin
                            shreg_n   = {shreg[5:0], 1'b0};
                            sda_oe_n  = ~shreg[6];
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                S_RD_MACK: begin
                    if (scl_rise) begin
                        if (!sda) begin
                            ptr_n     = ptr + 8'd1;
                            bit_cnt_n = '0;
                            state_n   = S_RD_DATA;
                        end else begin
                            state_n = S_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers and write report
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            ptr       <= ptr_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            rw        <= rw_n;
            wr_strobe <= we;
            if (we) begin
                wr_addr <= ptr;
                wr_data <= rx_byte;
            end
        end
    end

    // Register file; cleared on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) regs[i] <= '0;
        end else if (we) begin
            regs[ptr] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_sccb_target_regfile.sv
// Directed bench for sccb_target_regfile: a bit-banged SCCB master plus
// a write scoreboard fed when bytes are sent and drained on wr_strobe.
module tb_sccb_target_regfile;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 0;
    logic       rst_n;
    logic       scl, m_low;
    logic       sda_in, sda_oe, wr_strobe, busy;
    logic [7:0] wr_addr, wr_data, host_addr, host_rdata;

    typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    int checks = 0, failures = 0, extra_wr = 0;
    logic oe_seen = 0;
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1;

    always #5 clk = ~clk;

    // open-drain bus: low if master or target pulls
    assign sda_in = ~(m_low | sda_oe);

    sccb_target_regfile #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(rst_n), .scl_in(scl), .sda_in(sda_in),
        .sda_oe(sda_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .host_addr(host_addr), .host_rdata(host_rdata),
        .busy(busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // write monitor: pop the expected write on each strobe
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (wr_strobe) begin
            if (exp_q.size() == 0) begin
                extra_wr++;
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {24'b0, wr_addr}, {24'b0, mon_e.addr});
                chk("wr_data", {24'b0, wr_data}, {24'b0, mon_e.data});
            end
        end
    end

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 0; wait_q(1); scl = 1; wait_q(1);
        m_low = 1; wait_q(1); scl = 0; wait_q(1);
    endtask

    task automatic bus_stop();
        m_low = 1; wait_q(1); scl = 1; wait_q(1); m_low = 0; wait_q(1);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; wait_q(1); scl = 1; wait_q(2); scl = 0; wait_q(1);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low = 0; wait_q(1); scl = 1; wait_q(1);
        ack = ~sda_in;
        wait_q(1); scl = 0; wait_q(1);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            m_low = 0; wait_q(1); scl = 1; wait_q(1);
            d[i] = sda_in;
            wait_q(1); scl = 0; wait_q(1);
        end
        m_low = mack; wait_q(1); scl = 1; wait_q(2); scl = 0; wait_q(1);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic hread(input string tag, input logic [7:0] a, input logic [7:0] exp);
        host_addr = a;
        @(negedge clk);
        chk(tag, {24'b0, host_rdata}, {24'b0, exp});
    endtask

    initial begin
        rst_n = 0; scl = 1; m_low = 0; host_addr = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", {31'b0, sda_oe}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_wr_strobe", {31'b0, wr_strobe}, 0);
        chk("rst_wr_addr", {24'b0, wr_addr}, 0);
        chk("rst_wr_data", {24'b0, wr_data}, 0);
        chk("rst_host_rdata", {24'b0, host_rdata}, 0);
        rst_n = 1;
        repeat (4) @(negedge clk);

        // single write
        bus_start();
        chk("busy_after_start", {31'b0, busy}, 1);
        send_byte(8'h42, a0);
        send_byte(8'h12, a1);
        push_wr(8'h12, 8'h80);
        send_byte(8'h80, a2);
        bus_stop();
        chk("w1_dev_ack", {31'b0, a0}, 1);
        chk("w1_sub_ack", {31'b0, a1}, 1);
        chk("w1_data_ack", {31'b0, a2}, 1);
        chk("busy_after_stop", {31'b0, busy}, 0);
        hread("w1_reg12", 8'h12, 8'h80);

        // burst with pointer wrap
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'hFF, a1);
        push_wr(8'hFF, 8'hAA);
        send_byte(8'hAA, a2);
        push_wr(8'h00, 8'hBB);
        send_byte(8'hBB, a3);
        bus_stop();
        chk("burst_ack", {28'b0, a0, a1, a2, a3}, 32'hF);
        hread("burst_regFF", 8'hFF, 8'hAA);
        hread("burst_reg00", 8'h00, 8'hBB);

        // wrong device address
        oe_seen = 0;
        bus_start();
        send_byte(8'h40, a0);
        send_byte(8'h12, a1);
        send_byte(8'h34, a2);
        chk("ignore_busy", {31'b0, busy}, 1);
        bus_stop();
        chk("ignore_no_ack", {29'b0, a0, a1, a2}, 0);
        chk("ignore_oe_seen", {31'b0, oe_seen}, 0);
        chk("ignore_busy_stop", {31'b0, busy}, 0);
        hread("ignore_reg12", 8'h12, 8'h80);

        // write two bytes, then read back via repeated START
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'h3A, a1);
        push_wr(8'h3A, 8'h04);
        send_byte(8'h04, a2);
        push_wr(8'h3B, 8'h05);
        send_byte(8'h05, a3);
        bus_stop();
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'h3A, a1);
        bus_start();
        send_byte(8'h43, a2);
        chk("rd_acks", {29'b0, a0, a1, a2}, 32'h7);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        chk("rd_byte0", {24'b0, d0}, 32'h04);
        chk("rd_byte1", {24'b0, d1}, 32'h05);
        chk("rd_nack_release", {31'b0, sda_oe}, 0);
        bus_stop();
        chk("rd_busy_stop", {31'b0, busy}, 0);

        // partial byte before STOP is discarded
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'h20, a1);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        bus_stop();
        chk("partial_busy", {31'b0, busy}, 0);
        chk("partial_sda_oe", {31'b0, sda_oe}, 0);
        hread("partial_reg20", 8'h20, 8'h00);
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'h20, a1);
        push_wr(8'h20, 8'h5A);
        send_byte(8'h5A, a2);
        bus_stop();
        hread("after_partial_reg20", 8'h20, 8'h5A);

        // reset while the target drives a 0 read bit
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'h50, a1);
        push_wr(8'h50, 8'h0F);
        send_byte(8'h0F, a2);
        bus_stop();
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'h50, a1);
        bus_start();
        send_byte(8'h43, a2);
        chk("rst_rd_driving", {31'b0, sda_oe}, 1);
        #2 rst_n = 0;
        #1 chk("rst_rd_release", {31'b0, sda_oe}, 0);
        m_low = 0; scl = 1;
        for (int a = 0; a < 256; a++) hread("rst_reg_clear", a[7:0], 8'h00);
        rst_n = 1;
        repeat (4) @(negedge clk);

        // recovery after reset
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'h01, a1);
        push_wr(8'h01, 8'h77);
        send_byte(8'h77, a2);
        bus_stop();
        hread("recover_reg01", 8'h01, 8'h77);

        chk("wr_queue_empty", exp_q.size(), 0);
        chk("extra_wr_strobes", extra_wr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccb_target_regfile.md
Name: sccb_target_regfile

Overview:
SCCB/I2C target (responder) with an internal 8-bit register file. It is the counterpart of our camera configuration master and stands in for the OV7670 in system simulation and board loopback. It decodes 3-phase write and 2-phase read transactions from oversampled SCL/SDA lines, updates or returns register contents, and reports every write to the host side. Host logic can read any register at any time through a separate port.

Parameters:
DEV_ADDR, 7'h21, 7-bit target address; write byte is 8'h42, read byte is 8'h43.
SYNC_STAGES, 2, synchroniser flops on scl_in and sda_in (minimum 2).

Ports:
clk  input  1  system clock; must be at least 16x the SCL frequency.
reset  input  1  asynchronous, active-low reset.
scl_in  input  1  SCL line level; asynchronous input.
sda_in  input  1  SDA line level; asynchronous input.
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
wr_strobe  output  1  one-clk pulse per register write.
wr_addr  output  8  register address of the current write; valid while wr_strobe=1.
wr_data  output  8  register data of the current write; valid while wr_strobe=1.
host_addr  input  8  host read address.
host_rdata  output  8  regfile[host_addr]; combinational.
busy  output  1  1 from START until STOP.

Behaviour:
- Input conditioning
  - scl_in and sda_in pass through SYNC_STAGES flops, then one history flop.
  - Rise and fall events are derived from these; all events occur at least SYNC_STAGES+1 clk after the line changes.
- Bus conditions
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START and STOP are recognised in every state, including mid-byte.
  - Repeated START → DEV_ADDR; bit counter clears and sda_oe releases.
  - STOP → IDLE; sda_oe=0, busy=0.
- Bit timing
  - Bits are sampled on the SCL rising event, MSB first.
  - sda_oe changes only on the SCL falling event, except on STOP, START or reset.
- States: IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, IGNORE.
  - DEV_ADDR: collect 8 bits.
    - On a match of {DEV_ADDR, rw}: → DEV_ACK.
    - On a mismatch: → IGNORE, with no ACK and no side effects. IGNORE waits for START or STOP.
  - ACK generation (DEV_ACK/SUB_ACK/WR_ACK): on the falling edge after bit 8, sda_oe=1. On the next falling edge, sda_oe=0.
  - After DEV_ACK: rw=0 → SUB_ADDR; rw=1 → RD_DATA.
  - SUB_ADDR: the 8-bit byte loads ptr, then → SUB_ACK → WR_DATA.
  - WR_DATA: on the 8th sampled bit, regfile[ptr] is written.
    - Same clk: wr_strobe=1, wr_addr=ptr, wr_data=byte.
    - ptr increments, wrapping 8'hFF→8'h00, then → WR_ACK → WR_DATA.
  - RD_DATA: at the falling edge ending the previous ACK, the byte regfile[ptr] is latched into a shifter.
    - Each falling edge drives sda_oe = ~bit.
    - After 8 bits, release SDA on the falling edge → RD_MACK.
  - RD_MACK: sample SDA on the rising edge.
    - 0 (ACK): ptr increments with wrap → RD_DATA.
    - 1 (NACK): → IGNORE; SDA stays released.
- ptr persists across transactions; it is only cleared by reset.
- A START or STOP before 8 bits are complete discards the partial byte: no write, no ptr change.
- Reset (asynchronous, any state): state=IDLE, sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, ptr=0, all 256 registers = 8'h00. This takes effect immediately, including mid-read.
- A host read and an SCCB write to the same address in the same clk: host_rdata shows the old value that cycle and the new value the next cycle.

Test Plan:
- START, 0x42, 0x12, 0x80, STOP → three ACKs (sda_oe=1 in each 9th SCL period); one wr_strobe with wr_addr=0x12 and wr_data=0x80; host_addr=0x12 returns 0x80.
- Burst START, 0x42, 0xFF, 0xAA, 0xBB, STOP → writes FF=0xAA, then 00=0xBB (wrap); two wr_strobe pulses.
- START, 0x40, 0x12, 0x34, STOP → sda_oe never asserts; no wr_strobe; regfile unchanged; busy=1 until STOP.
- Write 0x42, 0x3A, 0x04, 0x05, STOP; then START, 0x42, 0x3A, repeated START, 0x43, master ACK, NACK, STOP → target drives 0x04 then 0x05; SDA released after the NACK.
- START, 0x42, 0x20, then 4 data bits, then STOP → no write; state IDLE; sda_oe=0; a next write to 0x20 succeeds.
- Assert reset while the target is driving a 0 read bit → sda_oe=0 within the same clk; all registers read 0x00 afterwards.
